// File: rtl/inst_mem_loader.sv
// Byte-stream program loader: assembles little-endian words from a framed
// stream, writes them to instruction memory and holds the core in reset meanwhile.
module inst_mem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  Clock_in,
    input  logic                  Reset_in,
    input  logic                  Load_Start_in,
    input  logic [7:0]            Byte_Data_in,
    input  logic                  Byte_Valid_in,
    output logic                  Byte_Ready_out,
    output logic [ADDR_WIDTH-1:0] Mem_Addr_out,
    output logic [31:0]           Mem_Data_out,
    output logic                  Mem_WE_out,
    output logic                  Core_Reset_out,
    output logic                  Done_out,
    output logic                  Error_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_HDR_HI = 3'd2;
    localparam logic [2:0] S_BYTES  = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_WIDTH:0] BASE = (ADDR_WIDTH+1)'(BASE_ADDR);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic                xfer;
    logic                start_ok;
    logic [7:0]          cnt_lo;
    logic [15:0]         hdr_count;
    logic [15:0]         remaining;
    logic [1:0]          byte_idx;
    logic [31:0]         word_buf;
    logic [31:0]         word_full;
    logic [ADDR_WIDTH:0] addr;
    logic                addr_ovf;

    assign xfer      = Byte_Valid_in & Byte_Ready_out;
    assign start_ok  = Load_Start_in & ((state == S_IDLE) | (state == S_DONE));
    assign hdr_count = {Byte_Data_in, cnt_lo};
    assign word_full = {Byte_Data_in, word_buf[23:0]};
    // The top address bit marks a write past the end of memory.
    assign addr_ovf  = addr[ADDR_WIDTH];

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (Load_Start_in) state_nxt = S_HDR_LO;
            S_HDR_LO: if (xfer) state_nxt = S_HDR_HI;
            S_HDR_HI: begin
                if (xfer) begin
                    state_nxt = (hdr_count == 16'd0) ? S_DONE : S_BYTES;
                end
            end
            S_BYTES:  if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = (remaining == 16'd1) ? S_DONE : S_BYTES;
            S_DONE:   if (Load_Start_in) state_nxt = S_HDR_LO;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_in or posedge Reset_in) begin
        if (Reset_in) begin
            state          <= S_IDLE;
            Byte_Ready_out <= 1'b0;
            Mem_WE_out     <= 1'b0;
            Mem_Addr_out   <= '0;
            Mem_Data_out   <= '0;
            Core_Reset_out <= 1'b1;
            Done_out       <= 1'b0;
            Error_out      <= 1'b0;
            cnt_lo         <= '0;
            remaining      <= '0;
            byte_idx       <= '0;
            word_buf       <= '0;
            addr           <= '0;
        end else begin
            state          <= state_nxt;
            Byte_Ready_out <= (state_nxt == S_HDR_LO) |
                              (state_nxt == S_HDR_HI) |
                              (state_nxt == S_BYTES);
            Core_Reset_out <= (state_nxt != S_DONE);
            Done_out       <= (state_nxt == S_DONE);
            Mem_WE_out     <= 1'b0;

            if (start_ok) begin
                Error_out <= 1'b0;
                byte_idx  <= '0;
            end

            if (state == S_HDR_LO && xfer) begin
                cnt_lo <= Byte_Data_in;
            end

            if (state == S_HDR_HI && xfer) begin
                remaining <= hdr_count;
                addr      <= BASE;
                byte_idx  <= '0;
            end

            if (state == S_BYTES && xfer) begin
                word_buf[byte_idx*8 +: 8] <= Byte_Data_in;
                byte_idx                  <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    if (addr_ovf) begin
                        Error_out <= 1'b1;
                    end else begin
                        Mem_WE_out   <= 1'b1;
                        Mem_Addr_out <= addr[ADDR_WIDTH-1:0];
                        Mem_Data_out <= word_full;
                    end
                end
            end

            if (state == S_WRITE) begin
                remaining <= remaining - 16'd1;
                // Saturate once past the top so later words also count as overflow.
                if (!addr_ovf) addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench: two loaders (default and a 4-word memory at base 2)
// share one byte stream; expected writes are queued per instance.
module tb_inst_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bdata = 8'h00;
    logic       bvalid = 1'b0;

    logic        rdy0, we0, crst0, done0, err0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic        rdy1, we1, crst1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] data1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [31:0] words[4];

    inst_mem_loader u_dut0 (
        .Clock_in(clk), .Reset_in(rst), .Load_Start_in(start),
        .Byte_Data_in(bdata), .Byte_Valid_in(bvalid),
        .Byte_Ready_out(rdy0), .Mem_Addr_out(addr0), .Mem_Data_out(data0),
        .Mem_WE_out(we0), .Core_Reset_out(crst0), .Done_out(done0),
        .Error_out(err0)
    );

    inst_mem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(2)) u_dut1 (
        .Clock_in(clk), .Reset_in(rst), .Load_Start_in(start),
        .Byte_Data_in(bdata), .Byte_Valid_in(bvalid),
        .Byte_Ready_out(rdy1), .Mem_Addr_out(addr1), .Mem_Data_out(data1),
        .Mem_WE_out(we1), .Core_Reset_out(crst1), .Done_out(done1),
        .Error_out(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [39:0] got,
                       input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && we0) begin
            last_we_cyc = cyc;
            if (q0.size() == 0) chk("we0_extra", {32'd0, addr0}, 40'hFF_FFFF_FFFF);
            else chk("wr0", {addr0, data0}, q0.pop_front());
        end
        if (!rst && we1) begin
            if (q1.size() == 0) chk("we1_extra", {32'd0, 6'd0, addr1}, 40'hFF_FFFF_FFFF);
            else chk("wr1", {6'd0, addr1, data1}, q1.pop_front());
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bvalid = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        bit sent = 0;
        while (!sent) begin
            @(negedge clk);
            bdata  = b;
            bvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bvalid && rdy0) sent = 1;
            n++;
            if (n > 200) begin
                chk("byte_timeout", 40'd0, 40'd1);
                sent = 1;
            end
        end
    endtask

    task automatic push_expect(input int n);
        for (int i = 0; i < n; i++) begin
            if (i < 256) q0.push_back({8'(i), words[i]});
            if (2 + i < 4) q1.push_back({8'(2 + i), words[i]});
        end
    endtask

    task automatic send_frame(input int n, input bit rnd, input bit mid_start);
        push_expect(n);
        send_byte(8'(n), rnd);
        send_byte(8'(n >> 8), rnd);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (mid_start && i == 0 && k == 2) pulse_start();
                send_byte(words[i][k*8 +: 8], rnd);
            end
        end
    endtask

    task automatic wait_done(output int dcyc);
        int n = 0;
        @(negedge clk);
        bvalid = 1'b0;
        while (!(done0 && done1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        dcyc = cyc;
        if (n >= 300) chk("done_timeout", 40'd0, 40'd1);
    endtask

    task automatic check_end(input string tag, input logic e1);
        chk({tag, "_done"}, {38'd0, done0, done1}, 40'd3);
        chk({tag, "_crst"}, {38'd0, crst0, crst1}, 40'd0);
        chk({tag, "_err"}, {38'd0, err0, err1}, {39'd0, e1});
        chk({tag, "_q"}, 40'(q0.size() + q1.size()), 40'd0);
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_addr", {30'd0, addr0, addr1}, 40'd0);
        chk("rst_data", {8'd0, data0 | data1}, 40'd0);
        chk("rst_err", {38'd0, err0, err1}, 40'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_hold", {34'd0, crst0, done0, rdy0, we0, crst1, rdy1},
                {34'd0, 6'b100010});
        end

        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
        pulse_start();
        chk("load_crst", {38'd0, crst0, rdy0}, 40'd3);
        send_frame(2, 0, 0);
        wait_done(dc);
        chk("done_lat", 40'(dc - last_we_cyc), 40'd1);
        check_end("fixed", 1'b0);

        pulse_start();
        chk("restart_done", {38'd0, done0, crst0}, 40'd1);
        send_frame(2, 1, 1);
        wait_done(dc);
        check_end("rand", 1'b0);

        words[0] = 32'hA0A1A2A3;
        words[1] = 32'hB4B5B6B7;
        words[2] = 32'hC8C9CACB;
        words[3] = 32'hDCDDDEDF;
        pulse_start();
        send_frame(4, 0, 0);
        wait_done(dc);
        check_end("ovf", 1'b1);

        pulse_start();
        chk("ovf_clear", {38'd0, err1, done1}, 40'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        bvalid = 1'b0;
        check_end("zero", 1'b0);

        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        bvalid = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("mid_rst", {33'd0, crst0, done0, rdy0, we0, err0, crst1, rdy1},
            {33'd0, 7'b1000010});
        rst = 1'b0;
        words[0] = 32'hCAFEF00D;
        pulse_start();
        send_frame(1, 0, 0);
        wait_done(dc);
        check_end("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer-side counterpart to the core's instruction fetch: a byte-stream program loader that fills instruction memory before the pipeline runs.
- Receives a framed byte stream on a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port (address, data, write enable).
- Holds the core in reset until the whole program is written, then releases it.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written; must be < 2^ADDR_WIDTH.

Ports:
- Clock_in  input  1  system clock, all state on rising edge.
- Reset_in  input  1  reset, asynchronous, active-high.
- Load_Start_in  input  1  single-cycle pulse that begins a load.
- Byte_Data_in  input  8  stream byte.
- Byte_Valid_in  input  1  Byte_Data_in valid.
- Byte_Ready_out  output  1  loader accepts a byte this cycle.
- Mem_Addr_out  output  ADDR_WIDTH  instruction memory word address.
- Mem_Data_out  output  32  instruction word to write.
- Mem_WE_out  output  1  instruction memory write enable, one-cycle pulse per word.
- Core_Reset_out  output  1  reset to the core; high while loading.
- Done_out  output  1  load completed.
- Error_out  output  1  program exceeded memory depth.

Behaviour:
- Reset values (asynchronous):
  - State IDLE.
  - Byte_Ready_out=0, Mem_WE_out=0, Mem_Addr_out=0, Mem_Data_out=0.
  - Core_Reset_out=1, Done_out=0, Error_out=0.
  - Internal word count, remaining count and byte index all 0.
- Byte transfer: occurs only on a cycle where Byte_Valid_in=1 and Byte_Ready_out=1.
- Byte_Ready_out is a registered function of state: 1 in HDR_LO, HDR_HI and BYTES; 0 otherwise.
- Frame format: word count N (16 bit, low byte first), then 4*N bytes. Each word is sent byte0 first; byte0 maps to [7:0] and byte3 to [31:24].
- FSM:
  - IDLE: on Load_Start_in -> HDR_LO. Core_Reset_out=1, Done_out=0, Error_out=0.
  - HDR_LO: on transfer, latch N[7:0] -> HDR_HI.
  - HDR_HI: on transfer, latch N[15:8].
    - If the full N==0 -> DONE.
    - Otherwise load remaining=N and address=BASE_ADDR -> BYTES.
  - BYTES: on each transfer, shift the byte into the word buffer at the current byte index and increment the index (mod 4). On the 4th transfer -> WRITE.
  - WRITE (exactly one cycle, no byte accepted):
    - Mem_WE_out=1, with Mem_Addr_out=current address and Mem_Data_out=assembled word, all registered and valid in the same cycle.
    - Next cycle: address+1, remaining-1, Mem_WE_out=0.
    - If remaining becomes 0 -> DONE, else -> BYTES.
  - DONE: Core_Reset_out=0 and Done_out=1, both set on the same edge that enters DONE. Stays until Load_Start_in or reset.
    - Load_Start_in in DONE: reassert Core_Reset_out=1, clear Done_out and Error_out -> HDR_LO.
- Throughput: at most one word per 5 cycles (4 bytes + WRITE).
- Load_Start_in in any state other than IDLE/DONE is ignored; no restart mid-load.
- Overflow: if a WRITE would target an address beyond 2^ADDR_WIDTH-1 (address register has wrapped past the top):
  - Mem_WE_out stays 0 and Error_out is set (sticky).
  - Remaining bytes are still consumed so the stream stays framed.
  - Load still ends in DONE and the core is released.
  - Track the address with one extra bit to detect the wrap.
- Byte_Valid_in toggling mid-word just stalls; partial-word state is held indefinitely.
- Reset mid-load: asynchronous return to IDLE with all reset values; the partially written memory is not cleaned.
- Mem_Addr_out and Mem_Data_out hold their last values outside WRITE.

Test Plan:
- Reset release, then no stimulus -> Core_Reset_out=1, Done_out=0, Byte_Ready_out=0, Mem_WE_out=0 held for 20 cycles.
- Start pulse; stream 02 00, 78 56 34 12, EF BE AD DE with Byte_Valid_in always 1 -> two WE pulses: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF. Done_out=1 and Core_Reset_out=0 one cycle after the 2nd WE.
- Same frame with Byte_Valid_in random 50% and a Load_Start_in pulse mid-stream -> identical writes, start pulse ignored, no byte lost or duplicated.
- Start; header 00 00 -> no WE pulse, DONE reached directly after HDR_HI, Error_out=0.
- ADDR_WIDTH=2, BASE_ADDR=2, N=4 -> writes at addr 2 and 3 only. Last two words are consumed with no WE, Error_out=1, Done_out=1.
- Reset asserted in the middle of word 1, then released; new start and a 1-word frame -> single write at BASE_ADDR with the correct word, no stale bytes from the aborted word.
